// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the pipelined adder/subtractor.
// Mode encoding, result flag bundle and pipeline depth helper.
package addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

  // One pipeline stage per segment, never fewer than one stage.
  function automatic int calc_stages(input int width, input int seg);
    int n;
    n = width / seg;
    if (n < 1) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result handshake bundle for addsub_pipe.
// slave is the adder's view, master is the producer/consumer view.
interface addsub_pipe_if #(
  parameter int WIDTH = 8
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_mode;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_overflow;
  logic             o_zero;

  modport slave (
    input  i_valid, i_a, i_b, i_mode, i_ready,
    output o_ready, o_valid, o_result, o_carry, o_overflow, o_zero
  );

  modport master (
    output i_valid, i_a, i_b, i_mode, i_ready,
    input  o_ready, o_valid, o_result, o_carry, o_overflow, o_zero
  );

endinterface

// File: rtl/addsub_seg.sv
// addsub_seg: combinational SEG-bit ripple adder built from FullAdder cells.
// The operand b_eff arrives already inverted for subtraction.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module addsub_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b_eff,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[SEG];

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    FullAdder u_fa (
      .a   (a[i]),
      .b   (b_eff[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: skewed-pipeline N-bit adder/subtractor, one stage per SEG-bit
// segment, valid/ready on both sides. Flags are formed in the last stage.
// Optional build macro ADDSUB_PIPE_SATURATE_EN clamps the result on signed
// overflow; otherwise the result wraps modulo 2^WIDTH.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  addsub_pipe_if.slave    bus
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  // Beat payload: operands ride along until their segment is consumed, and
  // finished result segments accumulate in sum as the beat moves down.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cy;
    logic             mode;
  } beat_t;

  beat_t             stg_in  [STAGES];
  beat_t             stg_nxt [STAGES];
  beat_t             stg_q   [STAGES];
  logic [SEG-1:0]    seg_sum [STAGES];
  logic [STAGES-1:0] seg_cout;
  logic [STAGES-1:0] valid_in;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load;
  logic              all_full;
  logic              ready_en;
  logic              fire;
  logic [WIDTH-1:0]  res_nxt;
  logic [WIDTH-1:0]  res_q;
  flags_t            flg_nxt;
  flags_t            flg_q;
  logic              sign_a;
  logic              sign_b;
  logic              sign_r;

  assign fire           = bus.i_valid & bus.o_ready;
  assign bus.o_ready    = ready_en & load[0];
  assign bus.o_valid    = valid_q[STAGES-1];
  assign bus.o_result   = res_q;
  assign bus.o_carry    = flg_q.carry;
  assign bus.o_overflow = flg_q.overflow;
  assign bus.o_zero     = flg_q.zero;

  // A stage may load when it or any stage below it is empty, or the result is taken.
  always_comb begin
    all_full = 1'b1;
    load     = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & valid_q[k];
      load[k]  = bus.i_ready | ~all_full;
    end
  end

  // Stage inputs: stage 0 takes the port operands with B conditioned for subtract.
  always_comb begin
    for (int k = 0; k < STAGES; k++) stg_in[k] = '0;
    valid_in       = '0;
    stg_in[0].a    = bus.i_a;
    stg_in[0].b    = (bus.i_mode == SUB) ? ~bus.i_b : bus.i_b;
    stg_in[0].cy   = bus.i_mode;
    stg_in[0].mode = bus.i_mode;
    valid_in[0]    = fire;
    for (int k = 1; k < STAGES; k++) begin
      stg_in[k]   = stg_q[k-1];
      valid_in[k] = valid_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_seg #(.SEG(SEG)) u_seg (
      .a    (stg_in[k].a[k*SEG +: SEG]),
      .b_eff(stg_in[k].b[k*SEG +: SEG]),
      .cin  (stg_in[k].cy),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k])
    );
  end

  // Merge each stage's segment sum and carry into the travelling beat.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_nxt[k]                   = stg_in[k];
      stg_nxt[k].sum[k*SEG +: SEG] = seg_sum[k];
      stg_nxt[k].cy                = seg_cout[k];
    end
  end

  // Final stage: derive borrow/carry, signed overflow, optional clamp and zero.
  always_comb begin
    sign_a           = stg_in[STAGES-1].a[WIDTH-1];
    sign_b           = stg_in[STAGES-1].b[WIDTH-1];
    res_nxt          = stg_nxt[STAGES-1].sum;
    sign_r           = res_nxt[WIDTH-1];
    flg_nxt          = '0;
    flg_nxt.overflow = (sign_a == sign_b) && (sign_r != sign_a);
    flg_nxt.carry    = stg_nxt[STAGES-1].cy ^ stg_in[STAGES-1].mode;
`ifdef ADDSUB_PIPE_SATURATE_EN
    if (flg_nxt.overflow) begin
      res_nxt = sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    res_nxt = stg_nxt[STAGES-1].sum;
`endif
    flg_nxt.zero = (res_nxt == '0);
  end

  // Pipeline registers: valid bits advance on load, payload only with a real beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_en <= 1'b0;
      valid_q  <= '0;
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
      res_q    <= '0;
      flg_q    <= '0;
    end else begin
      ready_en <= 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) valid_q[k] <= valid_in[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        if (load[k] && valid_in[k]) stg_q[k] <= stg_nxt[k];
      end
      if (load[STAGES-1] && valid_in[STAGES-1]) begin
        res_q <= res_nxt;
        flg_q <= flg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed bench for addsub_pipe with WIDTH=8, SEG=4.
// Expected values are hand-computed; the saturating build is covered when
// ADDSUB_PIPE_SATURATE_EN is defined.
module tb_addsub_pipe;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   sent;
  int   got;
  int   first_cyc;
  int   last_cyc;

  logic [7:0] exp_7f01;
  logic       exp_7f01_z;
  logic [7:0] exp_8001;
  logic [7:0] t_a   [3];
  logic [7:0] t_b   [3];
  logic       t_m   [3];
  logic [7:0] t_exp [3];

  addsub_pipe_if #(.WIDTH(8)) bus ();

  addsub_pipe #(.WIDTH(8), .SEG(4)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Hard stop in case the bench itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic mode, input logic valid);
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_mode  = mode;
    bus.i_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Send one beat into an empty pipe and check latency 2 plus all result fields.
  task automatic runBeat(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic mode, input logic [7:0] exp_res, input logic exp_c,
                         input logic exp_v, input logic exp_z);
    applyStimulus(a, b, mode, 1'b1);
    step();
    bus.i_valid = 1'b0;
    checkOutput({tag, "_latency"}, 32'(bus.o_valid), 32'(1'b0));
    step();
    checkOutput({tag, "_valid"},    32'(bus.o_valid),    32'(1'b1));
    checkOutput({tag, "_result"},   32'(bus.o_result),   32'(exp_res));
    checkOutput({tag, "_carry"},    32'(bus.o_carry),    32'(exp_c));
    checkOutput({tag, "_overflow"}, 32'(bus.o_overflow), 32'(exp_v));
    checkOutput({tag, "_zero"},     32'(bus.o_zero),     32'(exp_z));
    step();
  endtask

  initial begin
`ifdef ADDSUB_PIPE_SATURATE_EN
    exp_7f01   = 8'h7F;
    exp_7f01_z = 1'b0;
    exp_8001   = 8'h80;
`else
    exp_7f01   = 8'h80;
    exp_7f01_z = 1'b0;
    exp_8001   = 8'h7F;
`endif
    t_a[0] = 8'hFF; t_b[0] = 8'h01; t_m[0] = ADD; t_exp[0] = 8'h00;
    t_a[1] = 8'h40; t_b[1] = 8'h40; t_m[1] = ADD;
`ifdef ADDSUB_PIPE_SATURATE_EN
    t_exp[1] = 8'h7F;
`else
    t_exp[1] = 8'h80;
`endif
    t_a[2] = 8'h10; t_b[2] = 8'h20; t_m[2] = SUB; t_exp[2] = 8'hF0;

    // Reset state.
    rst_n       = 1'b0;
    bus.i_ready = 1'b1;
    applyStimulus(8'h00, 8'h00, ADD, 1'b0);
    #1;
    checkOutput("rst_valid",    32'(bus.o_valid),    0);
    checkOutput("rst_result",   32'(bus.o_result),   0);
    checkOutput("rst_carry",    32'(bus.o_carry),    0);
    checkOutput("rst_overflow", 32'(bus.o_overflow), 0);
    checkOutput("rst_zero",     32'(bus.o_zero),     0);
    checkOutput("rst_ready",    32'(bus.o_ready),    0);
    step();
    step();
    rst_n = 1'b1;
    step();
    checkOutput("ready_after_reset", 32'(bus.o_ready), 1);

    // Single beats through an empty pipe.
    $display("[TB] directed single beats");
    runBeat("add_3c_15", 8'h3C, 8'h15, ADD, 8'h51, 1'b0, 1'b0, 1'b0);
    runBeat("add_7f_01", 8'h7F, 8'h01, ADD, exp_7f01, 1'b0, 1'b1, exp_7f01_z);
    runBeat("sub_05_05", 8'h05, 8'h05, SUB, 8'h00, 1'b0, 1'b0, 1'b1);
    runBeat("sub_03_05", 8'h03, 8'h05, SUB, 8'hFE, 1'b1, 1'b0, 1'b0);
    runBeat("sub_80_01", 8'h80, 8'h01, SUB, exp_8001, 1'b0, 1'b1, 1'b0);

    // Offer six beats with the consumer stalled: only two fit.
    $display("[TB] stall and drain");
    bus.i_ready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      applyStimulus(8'(16 + sent), 8'(sent), ADD, 1'b1);
      #1;
      if (bus.o_ready) sent++;
      step();
    end
    checkOutput("stall_accepts", sent, 2);
    checkOutput("stall_ready",   32'(bus.o_ready),  0);
    checkOutput("stall_valid",   32'(bus.o_valid),  1);
    checkOutput("stall_result",  32'(bus.o_result), 32'h10);
    step();
    step();
    checkOutput("stall_hold_valid",  32'(bus.o_valid),  1);
    checkOutput("stall_hold_result", 32'(bus.o_result), 32'h10);

    // Release the consumer while still offering beats: both sides transfer.
    bus.i_ready = 1'b1;
    #1;
    checkOutput("ready_on_release", 32'(bus.o_ready), 1);
    got       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
      if (sent < 6) applyStimulus(8'(16 + sent), 8'(sent), ADD, 1'b1);
      else bus.i_valid = 1'b0;
      #1;
      if (bus.i_valid && bus.o_ready) sent++;
      if (bus.o_valid) begin
        checkOutput($sformatf("drain_beat%0d", got), 32'(bus.o_result), 32'(16 + 2 * got));
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      step();
    end
    bus.i_valid = 1'b0;
    checkOutput("drain_count", got, 6);
    checkOutput("drain_span",  last_cyc - first_cyc, 5);

    // Reset with two beats in flight.
    $display("[TB] reset mid-operation");
    bus.i_ready = 1'b0;
    applyStimulus(8'h7F, 8'h01, ADD, 1'b1);
    step();
    applyStimulus(8'hFF, 8'h01, ADD, 1'b1);
    step();
    bus.i_valid = 1'b0;
    checkOutput("inflight_valid", 32'(bus.o_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid",    32'(bus.o_valid),    0);
    checkOutput("midrst_result",   32'(bus.o_result),   0);
    checkOutput("midrst_carry",    32'(bus.o_carry),    0);
    checkOutput("midrst_overflow", 32'(bus.o_overflow), 0);
    checkOutput("midrst_zero",     32'(bus.o_zero),     0);
    checkOutput("midrst_ready",    32'(bus.o_ready),    0);
    bus.i_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      step();
      checkOutput($sformatf("post_rst_no_valid%0d", cyc), 32'(bus.o_valid), 0);
    end
    runBeat("post_rst_add", 8'h21, 8'h12, ADD, 8'h33, 1'b0, 1'b0, 1'b0);

    // Consumer ready toggling every cycle: three beats, none lost or repeated.
    $display("[TB] toggling consumer ready");
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      bus.i_ready = (cyc % 2 == 0);
      if (sent < 3) applyStimulus(t_a[sent], t_b[sent], t_m[sent], 1'b1);
      else bus.i_valid = 1'b0;
      #1;
      if (bus.i_valid && bus.o_ready) sent++;
      if (bus.o_valid && bus.i_ready) begin
        checkOutput($sformatf("toggle_beat%0d", got), 32'(bus.o_result), 32'(t_exp[got]));
        if (got == 0) begin
          checkOutput("toggle_ff01_carry", 32'(bus.o_carry), 1);
          checkOutput("toggle_ff01_zero",  32'(bus.o_zero),  1);
        end
        if (got == 1) checkOutput("toggle_4040_overflow", 32'(bus.o_overflow), 1);
        if (got == 2) checkOutput("toggle_1020_borrow",   32'(bus.o_carry),    1);
        got++;
      end
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    checkOutput("toggle_sent", sent, 3);
    checkOutput("toggle_got",  got,  3);
    checkOutput("toggle_no_dup0", 32'(bus.o_valid), 0);
    step();
    checkOutput("toggle_no_dup1", 32'(bus.o_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined N-bit adder/subtractor. Successor to the single-bit full adder cell.
- Splits the operands into SEG-bit segments and ripples the carry across one pipeline stage per segment.
- Uses a valid/ready handshake on both sides.
- Produces the result plus carry/borrow, signed overflow and zero flags. Sits between operand registers and the result bus of the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits per pipeline segment; STAGES = WIDTH/SEG, minimum 1.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  operand beat valid
- o_ready  output  1  block can accept a beat this cycle
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B
- i_mode  input  1  0 = A+B, 1 = A-B
- o_valid  output  1  result beat valid
- i_ready  input  1  downstream accepts result
- o_result  output  WIDTH  sum/difference
- o_carry  output  1  add: carry-out; sub: borrow (1 when A<B unsigned)
- o_overflow  output  1  signed two's-complement overflow
- o_zero  output  1  o_result == 0

Behaviour:
- Reset: i_clk single clock domain; i_rst_n asynchronous assert, synchronous deassert handled upstream.
  - On reset, all stage valid bits, o_valid, o_result, o_carry, o_overflow and o_zero clear to 0.
  - o_ready = 1 one cycle after reset release.
- Subtract: B is inverted and carry-in = 1. Add: carry-in = 0.
- Stage k (0..STAGES-1) computes segment k: bits [k*SEG +: SEG].
  - Carry-in comes from stage k-1's registered carry.
  - Not-yet-processed upper operand segments and finished lower result segments travel with the beat (skewed pipeline).
- Latency: exactly STAGES cycles from accepted input beat (i_valid & o_ready) to o_valid, absent stalls.
- Throughput: one beat per cycle.
- Handshake:
  - Stage k loads when its register is empty or stage k+1 (the output for the last stage) is loading/consumed. Combinational ready chain, no bubbles.
  - o_ready = !valid_0 | advance_0.
  - A beat is held with all fields stable while o_valid & !i_ready.
  - i_a/i_b/i_mode are ignored when i_valid = 0 or o_ready = 0.
- Flags: computed in the final stage from the final carry and operand/result sign bits.
  - Overflow, add: signs of A and B equal, and result sign differs.
  - Overflow, sub: signs of A and B differ, and result sign differs from A.
  - o_carry for sub = NOT raw carry-out.
- Boundary conditions:
  - Pipeline full with i_ready = 0: o_ready drops the same cycle the last free stage fills.
  - Simultaneous i_ready rise and new i_valid: both transfers happen; occupancy is unchanged.
  - Reset mid-operation: all in-flight beats are discarded; no partial result appears after release.
  - STAGES = 1: behaves as a single registered adder, latency 1.
  - Wrap-around: results are modulo 2^WIDTH unless saturation is enabled.

Optional Feature:
- Macro: ADDSUB_PIPE_SATURATE_EN.
- Defined: on signed overflow, o_result clamps to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow). o_overflow still reports 1. o_zero reflects the clamped value.
- Not defined: o_result wraps modulo 2^WIDTH. Ports are identical in both builds.

Decomposition:
- Package addsub_pkg:
  - mode encoding constants ADD = 1'b0, SUB = 1'b1
  - flags struct {carry, overflow, zero}
  - function computing STAGES from WIDTH and SEG
- Sub-module addsub_seg: combinational SEG-bit ripple adder built from FullAdder cells; inputs a, b_eff, cin; outputs sum, cout. Instantiated once per stage via generate.

Test Plan (WIDTH=8, SEG=4, STAGES=2):
- Reset then single beat A=0x3C, B=0x15, mode=0 -> two cycles later o_valid=1, result 0x51, carry 0, overflow 0, zero 0.
- A=0x7F, B=0x01, add -> result 0x80, overflow 1, carry 0. With ADDSUB_PIPE_SATURATE_EN: result 0x7F, overflow 1.
- A=0x05, B=0x05, sub -> result 0x00, zero 1, carry (borrow) 0. Then A=0x03, B=0x05, sub -> result 0xFE, borrow 1, overflow 0.
- Back-to-back 6 beats with i_ready=0 -> o_ready falls after 2 accepts. Release i_ready -> results emerge in order, one per cycle, values stable during the stall.
- Assert i_rst_n=0 with 2 beats in flight -> all outputs 0 immediately. After release, no stale o_valid; the next beat has latency 2.
- A=0xFF, B=0x01, add, with i_ready toggling every cycle -> result 0x00, carry 1, zero 1. No beat lost or duplicated.
